// File: rtl/pio_pattern_sequencer.sv
// Autonomous LED pattern sequencer: a CSR slave holds mode/period/seed, and a
// write-only master pushes each new pattern to the PIO data register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | disabled, timer held at 0, no PIO traffic
// S_COUNT | timer counting down from PERIOD-1; at 0 the pattern steps
// S_WRITE | one-cycle PIO write of the current pattern (step_q marks a step)
module pio_pattern_sequencer #(
   parameter int          DATA_W         = 4,
   parameter int          PERIOD_W       = 32,
   parameter int unsigned DEFAULT_PERIOD = 50000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   output logic        step_pulse
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic                ctrl_en;
   logic [1:0]          ctrl_mode;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] timer;
   logic [DATA_W-1:0]   pattern;
   logic [DATA_W-1:0]   pattern_stepped;
   logic [15:0]         step_cnt;
   logic                step_q, step_nxt;
   logic                load_timer, advance;

   logic                csr_wr, ctrl_wr, period_wr, pattern_wr, status_wr;
   logic                en_next;
   logic                busy;

   assign csr_wr     = s_chipselect & ~s_write_n;
   assign ctrl_wr    = csr_wr && (s_address == 2'd0);
   assign period_wr  = csr_wr && (s_address == 2'd1);
   assign pattern_wr = csr_wr && (s_address == 2'd2);
   assign status_wr  = csr_wr && (s_address == 2'd3);

   // Enable as it will be after this cycle, so a disabling write stops the FSM
   // on the same edge that clears the register bit.
   assign en_next = ctrl_wr ? s_writedata[0] : ctrl_en;
   assign busy    = (state != S_IDLE);

   always_comb begin
      pattern_stepped = pattern;
      case (ctrl_mode)
         2'b00:   pattern_stepped = {pattern[DATA_W-2:0], pattern[DATA_W-1]};
         2'b01:   pattern_stepped = {pattern[0], pattern[DATA_W-1:1]};
         2'b10:   pattern_stepped = pattern + DATA_W'(1);
         default: pattern_stepped = ~pattern;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      step_nxt   = 1'b0;
      load_timer = 1'b0;
      advance    = 1'b0;
      case (state)
         S_IDLE: begin
            if (en_next) state_nxt = S_WRITE;
         end
         S_COUNT: begin
            if (!en_next) begin
               state_nxt = S_IDLE;
            end else if (pattern_wr) begin
               // a fresh seed wins over a coincident expiry; that step is lost
               state_nxt = S_WRITE;
            end else if (timer == '0) begin
               state_nxt = S_WRITE;
               step_nxt  = 1'b1;
               advance   = 1'b1;
            end
         end
         S_WRITE: begin
            if (!en_next) begin
               state_nxt = S_IDLE;
            end else if (pattern_wr) begin
               state_nxt = S_WRITE;
            end else begin
               state_nxt  = S_COUNT;
               load_timer = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         step_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         step_q <= step_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= 2'b00;
         period    <= PERIOD_W'(DEFAULT_PERIOD);
      end else begin
         if (ctrl_wr) begin
            ctrl_en   <= s_writedata[0];
            ctrl_mode <= s_writedata[2:1];
         end
         if (period_wr) begin
            period <= (s_writedata[PERIOD_W-1:0] == '0) ? PERIOD_W'(1)
                                                         : s_writedata[PERIOD_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pattern <= DATA_W'(1);
      end else if (pattern_wr) begin
         pattern <= s_writedata[DATA_W-1:0];
      end else if (advance) begin
         pattern <= pattern_stepped;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer <= '0;
      end else if (state_nxt == S_IDLE) begin
         timer <= '0;
      end else if (load_timer) begin
         timer <= period - PERIOD_W'(1);
      end else if ((state == S_COUNT) && (timer != '0)) begin
         timer <= timer - PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         step_cnt <= 16'd0;
      end else if (status_wr) begin
         step_cnt <= 16'd0;
      end else if ((state == S_WRITE) && step_q) begin
         step_cnt <= step_cnt + 16'd1;
      end
   end

   always_comb begin
      s_readdata = 32'd0;
      case (s_address)
         2'd0:    s_readdata = {29'd0, ctrl_mode, ctrl_en};
         2'd1:    s_readdata = 32'(period);
         2'd2:    s_readdata = 32'(pattern);
         default: s_readdata = {15'd0, busy, step_cnt};
      endcase
   end

   // Master outputs decode straight from state so an async reset drops them at once.
   assign m_address    = 2'd0;
   assign m_chipselect = (state == S_WRITE);
   assign m_write_n    = ~m_chipselect;
   assign m_writedata  = m_chipselect ? 32'(pattern) : 32'd0;
   assign step_pulse   = m_chipselect & step_q;

endmodule
